uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1, clocks per serial bit; legal range 1..1024; default 1 pairs with uart_tx_fsm at one bit per clock.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 rxd  input  1  serial line; idle high; 8N1 frame, LSB first.
REQ-005 data  output  8  last correctly received byte.
REQ-006 valid  output  1  one-cycle pulse; data is new this cycle.
REQ-007 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 rxs denotes the line as seen by the FSM (see REQ-024/025).
REQ-010 States: IDLE, START, DATA, STOP, BREAK; the state register is 3 bits wide; undefined encodings go to IDLE next cycle.
REQ-011 IDLE: rxs==0 is start detection at cycle T; cycle counter cleared to 0 at T.
REQ-012 Start confirm point: T + CLKS_PER_BIT/2 (integer division); if 0 (CLKS_PER_BIT==1), confirmation occurs at T and IDLE goes directly to DATA.
REQ-013 START: at confirm point, rxs==0 -> DATA; rxs==1 -> IDLE (glitch rejected), no outputs pulsed.
REQ-014 Sample points: confirm + k*CLKS_PER_BIT; k=1..8 data bits 0..7, k=9 stop bit.
REQ-015 DATA: each data sample is shifted into an 8-bit shift register from the MSB side, so bit 0 ends in data[0]; a 3-bit counter advances 0..7; after bit 7 -> STOP.
REQ-016 STOP: at sample point, rxs==1 -> data<=shift register, valid=1 next cycle, -> IDLE; rxs==0 -> frame_err=1 next cycle, data unchanged, -> BREAK.
REQ-017 BREAK: stays until rxs==1, then -> IDLE; no start detection while in BREAK.
REQ-018 A new frame is accepted immediately after STOP: a start edge in the cycle after the stop sample is detected.
REQ-019 valid and frame_err are never high simultaneously and each is high for exactly one cycle per frame.
REQ-020 data holds its value between valid pulses.
REQ-021 The cycle counter is $clog2(CLKS_PER_BIT)+1 bits wide and never wraps within a bit period.

Reset
REQ-022 While rst_n==0 at a clock edge: state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, counters and shift register=0, synchroniser flops=1.
REQ-023 Reset asserted mid-frame aborts the frame; no valid or frame_err pulse is generated for it; after release, reception restarts at the next start detection.

Configuration
REQ-024 With UART_RX_SYNC_EN defined: rxd passes through a two-flop synchroniser before the FSM; all detection and sample points are delayed by 2 cycles.
REQ-025 Without UART_RX_SYNC_EN: rxs=rxd directly (same-clock source, e.g. uart_tx_fsm loopback); no added latency.

Verification
REQ-026 Macro off, CLKS_PER_BIT=1, rxd driven by uart_tx_fsm sending 8'hA5 -> valid pulses once with data=8'hA5, exactly 10 cycles after the start bit first appears on rxd.
REQ-027 Macro off, CLKS_PER_BIT=16, rxd low for 4 cycles then high -> state returns to IDLE, valid and frame_err stay 0, busy high for at most 9 cycles.
REQ-028 CLKS_PER_BIT=16, frame 8'h3C with stop bit 0, rxd held low 40 more cycles -> frame_err pulses once, data keeps previous value, busy stays high until rxd returns high.
REQ-029 CLKS_PER_BIT=1, back-to-back frames 8'h00 then 8'hFF with no idle gap -> two valid pulses, data 8'h00 then 8'hFF.
REQ-030 CLKS_PER_BIT=16, rst_n low for 1 cycle during bit 4 of 8'h5A -> no pulse for that frame; next frame 8'h81 -> data=8'h81.
REQ-031 Repeat REQ-026 with UART_RX_SYNC_EN defined -> same data, valid exactly 12 cycles after the start bit.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: start-bit confirm at mid-bit, eight LSB-first data bits, stop check.
// Define UART_RX_SYNC_EN to put a two-flop synchroniser on rxd (adds two cycles of latency).
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? (HALF - 1) : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          rxs_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_r;

  // two-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rxd};
    end
  end

  assign rxs_s = sync_r[1];
`else
  assign rxs_s = rxd;
`endif

  // receive FSM; busy is registered alongside each state change so it tracks state != IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rxs_s) begin
            cnt_r     <= {CW{1'b0}};
            bit_cnt_r <= 3'd0;
            busy      <= 1'b1;
            // with one clock per bit the detection cycle is already mid-bit
            state_r   <= (HALF == 0) ? DATA : START;
          end else begin
            busy <= 1'b0;
          end
        end
        START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (!rxs_s) begin
              state_r <= DATA;
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= {CW{1'b0}};
            shift_r   <= {rxs_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 1'b1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (rxs_s) begin
              data    <= shift_r;
              valid   <= 1'b1;
              state_r <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_r   <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        BREAK: begin
          // line held low: wait for it to return high before hunting for a start bit
          if (rxs_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= {CW{1'b0}};
          bit_cnt_r <= 3'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at one and sixteen clocks per bit; a scoreboard
// queue per instance holds expected bytes, popped whenever valid pulses.
module tb_uart_rx_fsm;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n1, rst_n16;
  logic       rxd1, rxd16;
  logic [7:0] data1, data16;
  logic       valid1, valid16, fe1, fe16, busy1, busy16;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int v1_cnt = 0, fe1_cnt = 0, v16_cnt = 0, fe16_cnt = 0;
  int v1_cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q16[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fsm #(.CLKS_PER_BIT(1)) u_rx1 (
    .clk(clk), .rst_n(rst_n1), .rxd(rxd1),
    .data(data1), .valid(valid1), .frame_err(fe1), .busy(busy1)
  );

  uart_rx_fsm #(.CLKS_PER_BIT(16)) u_rx16 (
    .clk(clk), .rst_n(rst_n16), .rxd(rxd16),
    .data(data16), .valid(valid16), .frame_err(fe16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample both instances once per cycle and score any output pulse
  task automatic observe();
    logic [7:0] e;
    if (valid1 === 1'b1 || fe1 === 1'b1) check("dut1_excl", {31'd0, valid1 & fe1}, 32'd0);
    if (valid1 === 1'b1) begin
      v1_cnt++;
      v1_cyc = cyc;
      check("dut1_sb_entry", {31'd0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut1_data", {24'd0, data1}, {24'd0, e});
      end
    end
    if (fe1 === 1'b1) fe1_cnt++;
    if (valid16 === 1'b1 || fe16 === 1'b1) check("dut16_excl", {31'd0, valid16 & fe16}, 32'd0);
    if (valid16 === 1'b1) begin
      v16_cnt++;
      check("dut16_sb_entry", {31'd0, q16.size() != 0}, 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("dut16_data", {24'd0, data16}, {24'd0, e});
      end
    end
    if (fe16 === 1'b1) fe16_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
  endtask

  // drive one 8N1 frame; a good stop bit pushes the byte to the scoreboard
  task automatic send(input int cpb, input logic [7:0] b, input logic stop_bit, output int start_cyc);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    if (stop_bit) begin
      if (cpb == 1) q1.push_back(b);
      else          q16.push_back(b);
    end
    for (int i = 0; i < 10; i++) begin
      if (cpb == 1) rxd1 = fr[i];
      else          rxd16 = fr[i];
      repeat (cpb) tick();
    end
  endtask

  initial begin
    int sc;
    int v_before, fe_before, bc, low_busy;
    logic [9:0] fr;

    rst_n1 = 1'b0; rst_n16 = 1'b0; rxd1 = 1'b1; rxd16 = 1'b1;
    repeat (3) tick();
    check("rst_data1",  {24'd0, data1}, 32'h00);
    check("rst_valid1", {31'd0, valid1}, 32'd0);
    check("rst_fe1",    {31'd0, fe1}, 32'd0);
    check("rst_busy1",  {31'd0, busy1}, 32'd0);
    check("rst_data16", {24'd0, data16}, 32'h00);
    check("rst_busy16", {31'd0, busy16}, 32'd0);
    rst_n1 = 1'b1; rst_n16 = 1'b1;
    repeat (4) tick();

    // single frame, one clock per bit: latency from start bit to valid
    v_before = v1_cnt;
    send(1, 8'hA5, 1'b1, sc);
    repeat (6) tick();
    check("a5_valid_count", v1_cnt - v_before, 32'd1);
    check("a5_latency", v1_cyc - sc, LAT);
    check("a5_data_hold", {24'd0, data1}, 32'hA5);
    check("a5_busy_idle", {31'd0, busy1}, 32'd0);

    // back-to-back frames with no idle gap
    v_before = v1_cnt;
    send(1, 8'h00, 1'b1, sc);
    send(1, 8'hFF, 1'b1, sc);
    repeat (6) tick();
    check("b2b_valid_count", v1_cnt - v_before, 32'd2);
    check("b2b_last_data", {24'd0, data1}, 32'hFF);

    // stop bit low at one clock per bit: frame error, data held
    v_before = v1_cnt; fe_before = fe1_cnt;
    send(1, 8'h55, 1'b0, sc);
    repeat (3) tick();
    check("fe1_busy_break", {31'd0, busy1}, 32'd1);
    rxd1 = 1'b1;
    repeat (6) tick();
    check("fe1_count", fe1_cnt - fe_before, 32'd1);
    check("fe1_no_valid", v1_cnt - v_before, 32'd0);
    check("fe1_data_held", {24'd0, data1}, 32'hFF);
    check("fe1_busy_idle", {31'd0, busy1}, 32'd0);

    // glitch shorter than half a bit is rejected
    v_before = v16_cnt; fe_before = fe16_cnt; bc = 0;
    rxd16 = 1'b0;
    repeat (4) begin tick(); if (busy16 === 1'b1) bc++; end
    rxd16 = 1'b1;
    repeat (20) begin tick(); if (busy16 === 1'b1) bc++; end
    check("glitch_busy_window", {31'd0, (bc >= 1) && (bc <= 9)}, 32'd1);
    check("glitch_no_valid", v16_cnt - v_before, 32'd0);
    check("glitch_no_fe", fe16_cnt - fe_before, 32'd0);
    check("glitch_busy_idle", {31'd0, busy16}, 32'd0);

    // normal frame at sixteen clocks per bit
    v_before = v16_cnt;
    send(16, 8'h96, 1'b1, sc);
    repeat (8) tick();
    check("x96_valid_count", v16_cnt - v_before, 32'd1);
    check("x96_data", {24'd0, data16}, 32'h96);

    // stop bit low then line held low: one frame_err, busy held through the break
    v_before = v16_cnt; fe_before = fe16_cnt; low_busy = 0;
    send(16, 8'h3C, 1'b0, sc);
    repeat (40) begin tick(); if (busy16 !== 1'b1) low_busy++; end
    check("break_busy_held", low_busy, 32'd0);
    check("break_fe_count", fe16_cnt - fe_before, 32'd1);
    check("break_no_valid", v16_cnt - v_before, 32'd0);
    check("break_data_held", {24'd0, data16}, 32'h96);
    rxd16 = 1'b1;
    repeat (6) tick();
    check("break_busy_idle", {31'd0, busy16}, 32'd0);

    // reset pulse mid bit 4 aborts the frame; the sender is reset along with it
    v_before = v16_cnt; fe_before = fe16_cnt;
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rxd16 = fr[i];
      repeat ((i == 4) ? 8 : 16) tick();
    end
    rst_n16 = 1'b0; rxd16 = 1'b1;
    tick();
    check("midrst_data", {24'd0, data16}, 32'h00);
    check("midrst_busy", {31'd0, busy16}, 32'd0);
    rst_n16 = 1'b1;
    repeat (40) tick();
    check("midrst_no_valid", v16_cnt - v_before, 32'd0);
    check("midrst_no_fe", fe16_cnt - fe_before, 32'd0);
    send(16, 8'h81, 1'b1, sc);
    repeat (8) tick();
    check("after_rst_valid", v16_cnt - v_before, 32'd1);
    check("after_rst_data", {24'd0, data16}, 32'h81);

    check("sb1_drained",  q1.size(), 32'd0);
    check("sb16_drained", q16.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
